rsrx_byte_fifo: RTL and testbench

- Receive-side byte buffer that sits directly downstream of the UART receiver, in the sample_clk domain.
- Watches the receiver's rxStatus[1] "data exists" flag and captures rxParallelData into a FIFO.
- Returns a one-cycle rxTrigger acknowledge so the receiver clears its flag.
- Presents the bytes to the camera-debug command logic through a first-word-fall-through pop interface, with full/level/overflow status.

---
 rtl/rsrx_byte_fifo.sv | 108 ++++++++++
 tb/tb_rsrx_byte_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rsrx_byte_fifo.sv
// Receive-side byte FIFO: captures bytes from the UART receiver's data-exists
// handshake, FWFT pop port. Define RSRX_BYTE_FIFO_DROP_OLDEST_EN for drop-oldest overflow.
module rsrx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 8
) (
  input  logic                  sample_clk,
  input  logic                  reset_n,
  input  logic [DW-1:0]         rxParallelData,
  input  logic [1:0]            rxStatus,
  output logic                  rxTrigger,
  input  logic                  rd_en,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  ovf_evt;
  logic                  grow;
  logic                  drop_head;
  logic                  do_write;
  logic                  adv_rd;
  logic                  unused_busy;

  assign unused_busy = rxStatus[0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rxStatus[1]) state_next = CAPTURE;
      CAPTURE: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rxTrigger is registered so it is high exactly during ACK.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rxTrigger <= 1'b0;
    end else begin
      state     <= state_next;
      rxTrigger <= (state == CAPTURE);
    end
  end

  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH_CNT);
  assign push     = (state == CAPTURE);
  assign pop      = rd_en && rd_valid;
  assign ovf_evt  = push && full && !pop;
  assign grow     = push && !ovf_evt;

`ifdef RSRX_BYTE_FIFO_DROP_OLDEST_EN
  // Overwrite the head slot (wr_ptr == rd_ptr when full) and step both pointers.
  assign drop_head = ovf_evt;
`else
  assign drop_head = 1'b0;
`endif

  assign do_write = grow || drop_head;
  assign adv_rd   = pop || drop_head;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (adv_rd)   rd_ptr <= rd_ptr + PTR_ONE;
      if (grow && !pop)      count <= count + CNT_ONE;
      else if (!grow && pop) count <= count - CNT_ONE;
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge sample_clk) begin
    if (do_write) mem[wr_ptr] <= rxParallelData;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: tb/tb_rsrx_byte_fifo.sv
// Scoreboard bench for rsrx_byte_fifo: a queue model tracks FIFO contents and
// overflow; a negedge monitor compares status and popped bytes.
module tb_rsrx_byte_fifo;

  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic [DW-1:0] rx_data   = '0;
  logic [1:0]    rx_status = '0;
  logic          rx_trig;
  logic          rd_en     = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          ovf_clr   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sb [$];
  bit m_ovf    = 1'b0;
  bit exp_trig = 1'b0;
  bit cap_next = 1'b0;
  bit pop_rand = 1'b0;
  int pop_div  = 4;
  bit mon_en   = 1'b0;
  bit in_ack   = 1'b0;

  always #5 clk = ~clk;

  rsrx_byte_fifo #(.DEPTH_LOG2(DL), .DW(DW)) dut (
    .sample_clk     (clk),
    .reset_n        (reset_n),
    .rxParallelData (rx_data),
    .rxStatus       (rx_status),
    .rxTrigger      (rx_trig),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; a capture lands on the edge the driver announces.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      m_ovf    = 1'b0;
      exp_trig = 1'b0;
    end else begin
      bit ev;
      ev = 1'b0;
      exp_trig = cap_next;
      if (cap_next) begin
        if (sb.size() < DEPTH) sb.push_back(rx_data);
        else begin
          ev = 1'b1;
`ifdef RSRX_BYTE_FIFO_DROP_OLDEST_EN
          void'(sb.pop_front());
          sb.push_back(rx_data);
`endif
        end
      end
      if (ev) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      chk("count", 32'(count), sb.size());
      chk("rd_valid", 32'(rd_valid), 32'(sb.size() > 0));
      chk("full", 32'(full), 32'(sb.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rxTrigger", 32'(rx_trig), 32'(exp_trig));
      if (sb.size() > 0) chk("rd_data", 32'(rd_data), 32'(sb[0]));
      if (rd_en && sb.size() > 0) void'(sb.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_rand) rd_en = ($urandom_range(0, pop_div - 1) == 0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pops(input int n);
    rd_en = 1'b1;
    idle(n);
    rd_en = 1'b0;
  endtask

  // Behaves like the receiver: hold keeps data-exists high through ACK with the next byte pending.
  task automatic send(input logic [DW-1:0] d, input bit hold, input bit pop_cap, input bit clr_cap);
    rx_data   = d;
    rx_status = 2'b10;
    if (in_ack) idle(1);
    idle(1);
    cap_next = 1'b1;
    if (pop_cap) rd_en = 1'b1;
    if (clr_cap) ovf_clr = 1'b1;
    idle(1);
    cap_next = 1'b0;
    if (pop_cap) rd_en = 1'b0;
    if (clr_cap) ovf_clr = 1'b0;
    if (hold) in_ack = 1'b1;
    else begin
      rx_status = 2'b00;
      in_ack    = 1'b0;
      idle(1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rxTrigger", 32'(rx_trig), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_overflow", 32'(overflow), 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(10);

    send(8'hA5, 1'b0, 1'b0, 1'b0);
    pops(1);
    idle(2);

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++)
        send(8'(b * 8 + i), (i < 7) && ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      pops(8);
    end
    idle(2);

    for (int i = 0; i < 17; i++) send(8'(16 + i), 1'b0, 1'b0, 1'b0);
    pops(18);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    idle(1);

    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1, 1'b0);
    pops(16);
    idle(1);

    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b0, 1'b1);
    idle(1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    idle(1);
    send(8'h77, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("ackrst_rxTrigger", 32'(rx_trig), 0);
    chk("ackrst_count", 32'(count), 0);
    chk("ackrst_overflow", 32'(overflow), 0);
    chk("ackrst_rd_valid", 32'(rd_valid), 0);
    rx_status = 2'b00;
    in_ack    = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);

    pop_rand = 1'b1;
    pop_div  = 8;
    for (int i = 0; i < 150; i++)
      send(8'($urandom), $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 15) == 0);
    pop_div = 2;
    for (int i = 0; i < 150; i++)
      send(8'($urandom), $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 15) == 0);
    if (in_ack) begin
      rx_status = 2'b00;
      idle(1);
      in_ack = 1'b0;
    end
    pop_rand = 1'b0;
    rd_en    = 1'b0;
    idle(1);
    pops(20);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
